// File: rtl/fdtd_src_ctrl.sv
// FDTD soft-source sequencer: fetches Jz for a step, streams each source cell's Ez
// through the source datapath and writes the result back. Optional macro: FDTD_SRC_SKIP_ZERO_EN.
// Ports: CLK/RST; start,time_step,n_src -> busy,done; cfg_we/idx/addr source table;
//        jz_rd_*, ez_rd_*, ez_wr_* memory side; dp_clken, dp_ez_c, dp_jz, dp_ez_n datapath side.
module fdtd_src_ctrl #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 12,
  parameter int N_SRC_MAX       = 16,
  parameter int SRC_IDX_W       = 4,
  parameter int T_WIDTH         = 16,
  parameter int CALC_LAT        = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [T_WIDTH-1:0]         time_step,
  input  logic [SRC_IDX_W:0]         n_src,
  output logic                       busy,
  output logic                       done,
  input  logic                       cfg_we,
  input  logic [SRC_IDX_W-1:0]       cfg_idx,
  input  logic [ADDR_WIDTH-1:0]      cfg_addr,
  output logic                       jz_rd_en,
  output logic [T_WIDTH-1:0]         jz_rd_addr,
  input  logic [FDTD_DATA_WIDTH-1:0] jz_rd_data,
  output logic                       ez_rd_en,
  output logic [ADDR_WIDTH-1:0]      ez_rd_addr,
  input  logic [FDTD_DATA_WIDTH-1:0] ez_rd_data,
  output logic                       dp_clken,
  output logic [FDTD_DATA_WIDTH-1:0] dp_ez_c,
  output logic [FDTD_DATA_WIDTH-1:0] dp_jz,
  input  logic [FDTD_DATA_WIDTH-1:0] dp_ez_n,
  output logic                       ez_wr_en,
  output logic [ADDR_WIDTH-1:0]      ez_wr_addr,
  output logic [FDTD_DATA_WIDTH-1:0] ez_wr_data
);

  typedef enum logic [2:0] {
    IDLE, JZ_RD, JZ_CAP, ISSUE, DRAIN, FIN
  } state_t;

  localparam logic [SRC_IDX_W:0] N_MAX = (SRC_IDX_W+1)'(N_SRC_MAX);
  localparam logic [SRC_IDX_W:0] ONE   = (SRC_IDX_W+1)'(1);

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0]      tab [N_SRC_MAX];
  logic [T_WIDTH-1:0]         ts_q;
  logic [SRC_IDX_W:0]         n_q;
  logic [SRC_IDX_W:0]         k_q;
  logic [SRC_IDX_W:0]         n_clamp;
  logic [FDTD_DATA_WIDTH-1:0] jz_q;
  logic [CALC_LAT:0]          dl_v;
  logic [ADDR_WIDTH-1:0]      dl_a [CALC_LAT+1];
  logic                       last_issue;
  logic                       last_wr;

  assign n_clamp    = (n_src > N_MAX) ? N_MAX : n_src;
  assign last_issue = (k_q == n_q - ONE);
  // reads stop before DRAIN, so the stream ends when only the oldest slot is live
  assign last_wr    = dl_v[CALC_LAT] && (dl_v[CALC_LAT-1:0] == '0);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = (n_clamp == '0) ? FIN : JZ_RD;
      JZ_RD:  state_nxt = JZ_CAP;
`ifdef FDTD_SRC_SKIP_ZERO_EN
      JZ_CAP: state_nxt = (jz_rd_data == '0) ? FIN : ISSUE;
`else
      JZ_CAP: state_nxt = ISSUE;
`endif
      ISSUE:  if (last_issue) state_nxt = DRAIN;
      DRAIN:  if (last_wr) state_nxt = FIN;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    jz_rd_en = (state == JZ_RD);
    ez_rd_en = (state == ISSUE);
    dp_clken = (state == ISSUE) || (state == DRAIN);
    done     = (state == FIN);
  end

  always_ff @(posedge CLK) begin
    if (cfg_we && !busy) tab[cfg_idx] <= cfg_addr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ts_q <= '0;
      n_q  <= '0;
      k_q  <= '0;
      jz_q <= '0;
      dl_v <= '0;
      for (int i = 0; i <= CALC_LAT; i++) dl_a[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        ts_q <= time_step;
        n_q  <= n_clamp;
      end
      if (state == JZ_CAP) jz_q <= jz_rd_data;
      if (state == ISSUE) k_q <= k_q + ONE;
      else                k_q <= '0;
      // one slot per read; the write leaves 1+CALC_LAT cycles later
      dl_v    <= {dl_v[CALC_LAT-1:0], ez_rd_en};
      dl_a[0] <= ez_rd_addr;
      for (int i = 1; i <= CALC_LAT; i++) dl_a[i] <= dl_a[i-1];
    end
  end

  assign jz_rd_addr = ts_q;
  assign ez_rd_addr = tab[k_q[SRC_IDX_W-1:0]];
  assign dp_ez_c    = ez_rd_data;
  assign dp_jz      = jz_q;
  assign ez_wr_en   = dl_v[CALC_LAT];
  assign ez_wr_addr = dl_a[CALC_LAT];
  assign ez_wr_data = dp_ez_n;

endmodule
